// File: rtl/div_unit.sv
// div_unit: iterative restoring divider (DIV/DIVU), quotient to LO, remainder to HI; signed mode built only with DIV_SIGNED_EN
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;
  state_t           state, state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] dvd, dsr, rem;
  logic [WIDTH-1:0] dvd_mag, dsr_mag, q_fix, r_fix;
  logic [WIDTH:0]   trial;
  // dvd doubles as the shifting dividend and the quotient being built
  assign trial = {rem, dvd[WIDTH-1]} - {1'b0, dsr};
`ifdef DIV_SIGNED_EN
  logic sign_q, sign_r, sign_d;
  // capture operand signs when a request is accepted
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      sign_d <= 1'b0;
    end else if (state == IDLE && start) begin
      sign_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      sign_r <= is_signed & dividend[WIDTH-1];
      sign_d <= is_signed & divisor[WIDTH-1];
    end
  end
  assign dvd_mag = sign_r ? -dvd : dvd;
  assign dsr_mag = sign_d ? -dsr : dsr;
  assign q_fix   = sign_q ? -dvd : dvd;
  assign r_fix   = sign_r ? -rem : rem;
`else
  logic unused_is_signed;
  assign unused_is_signed = is_signed;
  assign dvd_mag = dvd;
  assign dsr_mag = dsr;
  assign q_fix   = dvd;
  assign r_fix   = rem;
`endif
  // state register
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end
  // next state; cancel aborts any active state, even FIX and DONE
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    state_next = start ? PREP : IDLE;
      PREP:    state_next = CALC;
      CALC:    state_next = (count == '0) ? FIX : CALC;
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (cancel && state != IDLE) state_next = IDLE;
  end
  // status flags registered from the next state so they track the FSM exactly
  always_ff @(posedge clk) begin
    if (!resetn) begin
      busy         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      busy         <= state_next != IDLE;
      result_valid <= state_next == DONE;
    end
  end
  // operand latch, shift-subtract datapath and result registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      dvd         <= '0;
      dsr         <= '0;
      rem         <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        dvd <= dividend;
        dsr <= divisor;
      end
      if (state == PREP) begin
        dvd   <= dvd_mag;
        dsr   <= dsr_mag;
        rem   <= '0;
        count <= CW'(WIDTH - 1);
      end
      if (state == CALC) begin
        rem   <= trial[WIDTH] ? {rem[WIDTH-2:0], dvd[WIDTH-1]} : trial[WIDTH-1:0];
        dvd   <= {dvd[WIDTH-2:0], ~trial[WIDTH]};
        count <= count - 1'b1;
      end
      if (state == FIX && !cancel) begin
        quotient    <= q_fix;
        remainder   <= r_fix;
        div_by_zero <= dsr == '0;
      end
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized and directed checks of div_unit against an arithmetic reference model
module tb_div_unit;
  logic        clk, resetn, start, is_signed, cancel;
  logic [31:0] dividend, divisor;
  logic        busy, result_valid, div_by_zero;
  logic [31:0] quotient, remainder;
  int checks = 0;
  int errors = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .cancel(cancel), .busy(busy),
    .result_valid(result_valid), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // reference: divide magnitudes, then apply MIPS sign rules; x/0 gives all-ones magnitude
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] q, output logic [31:0] r, output logic z);
    logic sg;
    logic [31:0] ma, mb, mq, mr;
`ifdef DIV_SIGNED_EN
    sg = s;
`else
    sg = 1'b0;
    if (s) sg = 1'b0;
`endif
    ma = (sg && a[31]) ? 32'(0 - a) : a;
    mb = (sg && b[31]) ? 32'(0 - b) : b;
    if (mb == 0) begin
      mq = 32'hFFFF_FFFF;
      mr = ma;
    end else begin
      mq = ma / mb;
      mr = ma % mb;
    end
    q = (sg && (a[31] ^ b[31])) ? 32'(0 - mq) : mq;
    r = (sg && a[31]) ? 32'(0 - mr) : mr;
    z = (b == 0);
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] eq, er;
    logic ez;
    int n;
    ref_div(a, b, s, eq, er, ez);
    start = 1'b1; dividend = a; divisor = b; is_signed = s;
    tick;
    start = 1'b0; cancel = 1'b0;
    dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom);
    n = 1;
    while (!result_valid && n < 40) begin
      check("busy_run", 32'(busy), 32'd1);
      tick;
      n++;
    end
    check("latency", 32'(n), 32'd35);
    check("quot", quotient, eq);
    check("rem", remainder, er);
    check("dbz", 32'(div_by_zero), 32'(ez));
    tick;
    check("busy_end", 32'(busy), 32'd0);
    check("valid_pulse", 32'(result_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] pq, pr, eq, er, a, b;
    logic pz, ez;
    int n, pulses, first;
    resetn = 1'b0; start = 1'b0; is_signed = 1'b0; cancel = 1'b0;
    dividend = 0; divisor = 0;
    tick; tick;
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(result_valid), 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_dbz", 32'(div_by_zero), 0);
    resetn = 1'b1;
    tick;

    do_op(32'd100, 32'd7, 1'b0);
    do_op(32'hFFFF_FFF9, 32'd2, 1'b1);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    do_op(32'd5, 32'd0, 1'b0);
    do_op(32'd5, 32'd0, 1'b1);
    do_op(32'hFFFF_FFFB, 32'd0, 1'b1);
    do_op(32'd0, 32'd9, 1'b0);
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0);

    // start together with cancel in IDLE is accepted
    cancel = 1'b1;
    do_op(32'd1000, 32'd33, 1'b0);

    // cancel during CALC, then restart immediately
    pq = quotient; pr = remainder; pz = div_by_zero;
    start = 1'b1; dividend = 32'd77; divisor = 32'd3; is_signed = 1'b0;
    tick;
    start = 1'b0;
    for (int i = 1; i < 10; i++) begin
      if (result_valid) check("cancel_no_valid", 32'(result_valid), 0);
      tick;
    end
    cancel = 1'b1;
    tick;
    cancel = 1'b0;
    check("cancel_busy", 32'(busy), 0);
    check("cancel_valid", 32'(result_valid), 0);
    check("cancel_q", quotient, pq);
    check("cancel_r", remainder, pr);
    check("cancel_dbz", 32'(div_by_zero), 32'(pz));
    do_op(32'd123456, 32'd789, 1'b0);

    // cancel in FIX keeps previous outputs
    pq = quotient; pr = remainder; pz = div_by_zero;
    start = 1'b1; dividend = 32'd50; divisor = 32'd0; is_signed = 1'b0;
    tick;
    start = 1'b0;
    for (int i = 0; i < 33; i++) tick;
    cancel = 1'b1;
    tick;
    cancel = 1'b0;
    check("fixcan_busy", 32'(busy), 0);
    check("fixcan_valid", 32'(result_valid), 0);
    check("fixcan_q", quotient, pq);
    check("fixcan_r", remainder, pr);
    check("fixcan_dbz", 32'(div_by_zero), 32'(pz));
    tick;
    check("fixcan_valid2", 32'(result_valid), 0);

    // second start while busy is ignored
    ref_div(32'd999, 32'd10, 1'b0, eq, er, ez);
    start = 1'b1; dividend = 32'd999; divisor = 32'd10; is_signed = 1'b0;
    tick;
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    start = 1'b1; dividend = 32'd7; divisor = 32'd7;
    tick;
    start = 1'b0;
    pulses = 0; first = 0;
    for (n = 6; n < 50; n++) begin
      if (result_valid) begin
        pulses++;
        if (first == 0) first = n;
        check("ign_q", quotient, eq);
        check("ign_r", remainder, er);
      end
      tick;
    end
    check("ign_pulses", 32'(pulses), 1);
    check("ign_latency", 32'(first), 35);

    // reset during CALC
    start = 1'b1; dividend = 32'd4000; divisor = 32'd13; is_signed = 1'b0;
    tick;
    start = 1'b0;
    for (int i = 0; i < 15; i++) tick;
    resetn = 1'b0;
    tick;
    check("mrst_busy", 32'(busy), 0);
    check("mrst_valid", 32'(result_valid), 0);
    check("mrst_q", quotient, 0);
    check("mrst_r", remainder, 0);
    check("mrst_dbz", 32'(div_by_zero), 0);
    resetn = 1'b1;
    tick;
    do_op(32'd4000, 32'd13, 1'b0);

    // randomized operations with corner-biased divisors
    for (int k = 0; k < 24; k++) begin
      a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'($urandom);
        default: b = 32'hFFFF_FFFF;
      endcase
      do_op(a, b, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
